// File: rtl/dm_store_buffer.sv
// Posted-write store buffer: DEPTH-entry FIFO between M-stage stores and data memory,
// with per-byte load forwarding. Optional store coalescing via `define STORE_COALESCE_EN.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic [31:0] cpu_rdata,
    output logic        store_stall,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wvalid,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wbyteen,
    input  logic        mem_wready
);

    logic [29:0]      ent_waddr  [DEPTH];
    logic [31:0]      ent_data   [DEPTH];
    logic [3:0]       ent_byteen [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic             store;
    logic             full;
    logic             enq;
    logic             deq;
    logic             coalesce_hit;
    logic [PTR_W-1:0] fwd_idx;
    logic [31:0]      fwd_rdata;
    logic             addr_lsb_unused;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    assign store = |cpu_byteen;
    assign full  = (count == (PTR_W+1)'(DEPTH));

`ifdef STORE_COALESCE_EN
    logic [PTR_W-1:0] tail_prev;
    assign tail_prev = tail - PTR_W'(1);
    // count>=2 guarantees the youngest entry is never the head being handed to memory.
    assign coalesce_hit = store && (count >= (PTR_W+1)'(2)) &&
                          (ent_waddr[tail_prev] == cpu_addr[31:2]);
`else
    assign coalesce_hit = 1'b0;
`endif

    // Stall looks only at the registered count, never at mem_wready.
    assign store_stall = store && full && !coalesce_hit;
    assign enq         = store && !full && !coalesce_hit;
    assign deq         = mem_wvalid && mem_wready;

    assign mem_wvalid  = (count != '0);
    assign mem_waddr   = {ent_waddr[head], 2'b00};
    assign mem_wdata   = ent_data[head];
    assign mem_wbyteen = ent_byteen[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload carries no reset; validity is defined solely by head/count.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_waddr[tail]  <= cpu_addr[31:2];
            ent_data[tail]   <= cpu_wdata;
            ent_byteen[tail] <= cpu_byteen;
        end
`ifdef STORE_COALESCE_EN
        if (coalesce_hit) begin
            ent_data[tail_prev]   <= merge_bytes(ent_data[tail_prev], cpu_wdata, cpu_byteen);
            ent_byteen[tail_prev] <= ent_byteen[tail_prev] | cpu_byteen;
        end
`endif
    end

    // Walk oldest to youngest so the youngest matching byte overrides earlier ones.
    always_comb begin
        fwd_rdata = mem_rdata;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (ent_waddr[fwd_idx] == cpu_addr[31:2]))
                fwd_rdata = merge_bytes(fwd_rdata, ent_data[fwd_idx], ent_byteen[fwd_idx]);
        end
    end

    assign cpu_rdata       = fwd_rdata;
    assign mem_raddr       = {cpu_addr[31:2], 2'b00};
    assign addr_lsb_unused = ^cpu_addr[1:0];

endmodule
